grf_dump_reader: RTL and testbench

Sequential read-side client of the general register file. On a `start` pulse it walks a configurable range of register addresses through one GRF read port, captures each word, and streams {address, data} pairs out over a valid/ready handshake, accumulating a 32-bit wrap-around checksum. It sits beside the CPU datapath as a debug/verification port, the consumer of register state that the write port produces. It never writes the register file.

---
 rtl/grf_dump_reader.sv | 121 ++++++++++++
 tb/tb_grf_dump_reader.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_dump_reader.sv
// Debug read-side client of the general register file: walks a register range through one
// read port and streams {address, data} pairs over valid/ready while accumulating a checksum.
module grf_dump_reader #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter bit          SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD,
        DONE
    } state_t;

    state_t      state, state_n;
    logic [4:0]  idx, idx_n;
    logic        out_valid_n;
    logic [4:0]  out_addr_n;
    logic [31:0] out_data_n;
    logic [31:0] checksum_n;
    logic        is_last;
    logic        skip_word;

    assign is_last   = (idx == LAST_IDX);
    assign skip_word = SKIP_ZERO && (rd_data == 32'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= FIRST_IDX;
            out_valid <= 1'b0;
            out_addr  <= 5'd0;
            out_data  <= 32'h0;
            checksum  <= 32'h0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            out_valid <= out_valid_n;
            out_addr  <= out_addr_n;
            out_data  <= out_data_n;
            checksum  <= checksum_n;
        end
    end

    // Output word registers only change in READ, so they stay frozen through HOLD backpressure.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        out_valid_n = out_valid;
        out_addr_n  = out_addr;
        out_data_n  = out_data;
        checksum_n  = checksum;
        rd_addr     = FIRST_IDX;
        busy        = 1'b1;
        done        = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    idx_n      = FIRST_IDX;
                    checksum_n = 32'h0;
                    state_n    = READ;
                end
            end
            READ: begin
                rd_addr    = idx;
                out_data_n = rd_data;
                out_addr_n = idx;
                if (skip_word) begin
                    if (is_last) begin
                        state_n = DONE;
                    end else begin
                        idx_n = idx + 5'd1;
                    end
                end else begin
                    out_valid_n = 1'b1;
                    state_n     = HOLD;
                end
            end
            HOLD: begin
                rd_addr = idx;
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    checksum_n  = checksum + out_data;
                    if (is_last) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + 5'd1;
                        state_n = READ;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_grf_dump_reader.sv
// Bench for grf_dump_reader: three differently parameterised instances share one clock/reset,
// each reading its own register file model; dumps are compared against a queue-based model.
module tb_grf_dump_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b1;
    logic [1:0] sel = 2'd0;

    logic [2:0]  start_w, ready_w, valid_w, busy_w, done_w;
    logic [4:0]  rd_addr_w [3];
    logic [31:0] rd_data_w [3];
    logic [4:0]  oaddr_w [3];
    logic [31:0] odata_w [3];
    logic [31:0] chk_w [3];
    logic [31:0] grf [3][32];

    logic        obs_valid, obs_busy, obs_done;
    logic [4:0]  obs_addr;
    logic [31:0] obs_data, obs_chk;

    int checks = 0;
    int failures = 0;

    logic [4:0]  got_addr[$];
    logic [31:0] got_data[$];
    logic [4:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_sum;
    int          exp_cycles;
    int          done_cyc;
    logic [31:0] chk_at_done;
    bit          timed_out;
    int          proto_err;

    always #5 clk = ~clk;

    // Register file model: register 0 always reads as zero.
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            rd_data_w[n] = (rd_addr_w[n] == 5'd0) ? 32'h0 : grf[n][rd_addr_w[n]];
            start_w[n]   = (sel == 2'(n)) && start;
            ready_w[n]   = (sel == 2'(n)) ? ready : 1'b1;
        end
    end

    assign obs_valid = valid_w[sel];
    assign obs_busy  = busy_w[sel];
    assign obs_done  = done_w[sel];
    assign obs_addr  = oaddr_w[sel];
    assign obs_data  = odata_w[sel];
    assign obs_chk   = chk_w[sel];

    grf_dump_reader dut0 (
        .clk(clk), .reset(reset), .start(start_w[0]), .rd_addr(rd_addr_w[0]),
        .rd_data(rd_data_w[0]), .out_valid(valid_w[0]), .out_ready(ready_w[0]),
        .out_addr(oaddr_w[0]), .out_data(odata_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .checksum(chk_w[0])
    );

    grf_dump_reader #(.FIRST_REG(0), .LAST_REG(7), .SKIP_ZERO(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start_w[1]), .rd_addr(rd_addr_w[1]),
        .rd_data(rd_data_w[1]), .out_valid(valid_w[1]), .out_ready(ready_w[1]),
        .out_addr(oaddr_w[1]), .out_data(odata_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .checksum(chk_w[1])
    );

    grf_dump_reader #(.FIRST_REG(1), .LAST_REG(2), .SKIP_ZERO(1'b0)) dut2 (
        .clk(clk), .reset(reset), .start(start_w[2]), .rd_addr(rd_addr_w[2]),
        .rd_data(rd_data_w[2]), .out_valid(valid_w[2]), .out_ready(ready_w[2]),
        .out_addr(oaddr_w[2]), .out_data(odata_w[2]), .busy(busy_w[2]),
        .done(done_w[2]), .checksum(chk_w[2])
    );

    // Reference model: which words a dump should emit, their sum, and the done cycle at full ready.
    task automatic build_model(input int n);
        int first, last;
        bit skip;
        logic [31:0] v;
        first = (n == 2) ? 1 : 0;
        last  = (n == 0) ? 31 : ((n == 1) ? 7 : 2);
        skip  = (n == 1);
        exp_addr.delete();
        exp_data.delete();
        exp_sum    = 32'h0;
        exp_cycles = 1;
        for (int i = first; i <= last; i++) begin
            v = (i == 0) ? 32'h0 : grf[n][i];
            if (skip && v == 32'h0) begin
                exp_cycles += 1;
            end else begin
                exp_addr.push_back(5'(i));
                exp_data.push_back(v);
                exp_sum    += v;
                exp_cycles += 2;
            end
        end
    endtask

    // Runs one dump on the selected instance, collecting transfers; mode 1 randomises out_ready.
    task automatic run_dump(input int mode, input bit mid_start);
        bit pv, pr;
        logic [4:0] pa;
        logic [31:0] pd;
        pv = 0; pr = 0; pa = '0; pd = '0;
        got_addr.delete();
        got_data.delete();
        done_cyc  = -1;
        timed_out = 0;
        proto_err = 0;
        @(negedge clk);
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 600; c++) begin
            start = mid_start && (c == 2);
            if (pv && !pr && (!obs_valid || obs_addr !== pa || obs_data !== pd))
                proto_err++;
            if (obs_done) begin
                done_cyc    = c;
                chk_at_done = obs_chk;
                break;
            end
            ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (obs_valid && ready) begin
                got_addr.push_back(obs_addr);
                got_data.push_back(obs_data);
            end
            pv = obs_valid; pr = ready; pa = obs_addr; pd = obs_data;
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b1;
        if (done_cyc < 0) timed_out = 1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if (oaddr_w[0] !== 5'd0 || odata_w[0] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_out_word: got addr=%0d data=%h expected 0/0", oaddr_w[0], odata_w[0]);
        end
        checks++;
        if (rd_addr_w[2] !== 5'd1) begin
            failures++;
            $display("[TB] FAIL reset_rd_addr_first: got %0d expected 1", rd_addr_w[2]);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0 || done_w[0] !== 1'b0 ||
                chk_w[0] !== 32'h0 || rd_addr_w[0] !== 5'd0) begin
                failures++;
                $display("[TB] FAIL reset_idle[%0d]: got busy=%b valid=%b done=%b chk=%h rd_addr=%0d expected 0 0 0 0 0",
                         c, busy_w[0], valid_w[0], done_w[0], chk_w[0], rd_addr_w[0]);
            end
        end
    endtask

    task automatic test_full_dump;
        sel = 2'd0;
        for (int i = 0; i < 32; i++) grf[0][i] = 32'(i * 16);
        build_model(0);
        run_dump(0, 0);
        checks++;
        if (timed_out || got_addr.size() != 32) begin
            failures++;
            $display("[TB] FAIL full_count: got %0d words (timeout=%0d) expected 32", got_addr.size(), timed_out);
        end
        for (int k = 0; k < got_addr.size() && k < exp_addr.size(); k++) begin
            checks++;
            if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
                failures++;
                $display("[TB] FAIL full_word[%0d]: got %0d/%h expected %0d/%h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
            end
        end
        checks++;
        if (done_cyc != 65) begin
            failures++;
            $display("[TB] FAIL full_done_cycle: got %0d expected 65", done_cyc);
        end
        checks++;
        if (chk_at_done !== 32'h1F00 || chk_at_done !== exp_sum) begin
            failures++;
            $display("[TB] FAIL full_checksum: got %h expected %h", chk_at_done, exp_sum);
        end
        @(negedge clk);
        checks++;
        if (obs_done !== 1'b0 || obs_busy !== 1'b0 || obs_chk !== 32'h1F00) begin
            failures++;
            $display("[TB] FAIL full_after_done: got done=%b busy=%b chk=%h expected 0 0 1f00", obs_done, obs_busy, obs_chk);
        end
    endtask

    task automatic test_backpressure;
        int stalled, dcyc;
        sel = 2'd0;
        stalled = 0;
        dcyc = -1;
        for (int i = 0; i < 32; i++) grf[0][i] = 32'(i * 16);
        got_addr.delete();
        got_data.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (obs_done) begin
                dcyc = c;
                break;
            end
            if (obs_valid && obs_addr == 5'd3 && stalled < 5) begin
                ready = 1'b0;
                stalled++;
            end else begin
                ready = 1'b1;
            end
            if (stalled > 0 && stalled <= 5 && !ready) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_addr !== 5'd3 || obs_data !== 32'h30) begin
                    failures++;
                    $display("[TB] FAIL bp_stable[%0d]: got valid=%b addr=%0d data=%h expected 1 3 30", stalled, obs_valid, obs_addr, obs_data);
                end
            end
            if (obs_valid && ready) begin
                got_addr.push_back(obs_addr);
                got_data.push_back(obs_data);
            end
            @(negedge clk);
        end
        ready = 1'b1;
        checks++;
        if (got_addr.size() != 32 || stalled != 5) begin
            failures++;
            $display("[TB] FAIL bp_count: got %0d words stalled=%0d expected 32 words stalled=5", got_addr.size(), stalled);
        end
        for (int k = 0; k < got_addr.size() && k < 32; k++) begin
            checks++;
            if (got_addr[k] !== 5'(k) || got_data[k] !== 32'(k * 16)) begin
                failures++;
                $display("[TB] FAIL bp_word[%0d]: got %0d/%h expected %0d/%h", k, got_addr[k], got_data[k], k, k * 16);
            end
        end
        checks++;
        if (dcyc != 70 || obs_chk !== 32'h1F00) begin
            failures++;
            $display("[TB] FAIL bp_done: got cycle=%0d chk=%h expected 70 1f00", dcyc, obs_chk);
        end
    endtask

    task automatic test_skip_zero;
        sel = 2'd1;
        for (int i = 0; i < 32; i++) grf[1][i] = 32'h0;
        grf[1][2] = 32'hDEADBEEF;
        grf[1][5] = 32'h1;
        build_model(1);
        run_dump(0, 0);
        checks++;
        if (timed_out || got_addr.size() != 2) begin
            failures++;
            $display("[TB] FAIL skip_count: got %0d words (timeout=%0d) expected 2", got_addr.size(), timed_out);
        end
        if (got_addr.size() == 2) begin
            checks++;
            if (got_addr[0] !== 5'd2 || got_addr[1] !== 5'd5 || got_data[0] !== 32'hDEADBEEF || got_data[1] !== 32'h1) begin
                failures++;
                $display("[TB] FAIL skip_words: got %0d/%h %0d/%h expected 2/deadbeef 5/1", got_addr[0], got_data[0], got_addr[1], got_data[1]);
            end
        end
        checks++;
        if (chk_at_done !== 32'hDEADBEF0) begin
            failures++;
            $display("[TB] FAIL skip_checksum: got %h expected deadbef0", chk_at_done);
        end
        checks++;
        if (done_cyc != exp_cycles) begin
            failures++;
            $display("[TB] FAIL skip_done_cycle: got %0d expected %0d", done_cyc, exp_cycles);
        end
    endtask

    task automatic test_wrap_ignored_start;
        sel = 2'd2;
        grf[2][1] = 32'hFFFFFFFF;
        grf[2][2] = 32'hFFFFFFFF;
        run_dump(0, 1);
        checks++;
        if (timed_out || got_addr.size() != 2 || done_cyc != 5) begin
            failures++;
            $display("[TB] FAIL wrap_count: got %0d words done=%0d expected 2 words done=5", got_addr.size(), done_cyc);
        end
        checks++;
        if (chk_at_done !== 32'hFFFFFFFE) begin
            failures++;
            $display("[TB] FAIL wrap_checksum: got %h expected fffffffe", chk_at_done);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (obs_busy !== 1'b0 || obs_valid !== 1'b0 || obs_chk !== 32'hFFFFFFFE) begin
                failures++;
                $display("[TB] FAIL wrap_idle_after[%0d]: got busy=%b valid=%b chk=%h expected 0 0 fffffffe", c, obs_busy, obs_valid, obs_chk);
            end
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 3; it++) begin
            for (int n = 0; n < 2; n++) begin
                for (int i = 0; i < 32; i++)
                    grf[n][i] = (n == 1 && $urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
                sel = 2'(n);
                build_model(n);
                run_dump(1, 0);
                checks++;
                if (timed_out || got_addr.size() != exp_addr.size() || proto_err != 0) begin
                    failures++;
                    $display("[TB] FAIL rand_count[%0d.%0d]: got %0d words proto_err=%0d expected %0d words",
                             it, n, got_addr.size(), proto_err, exp_addr.size());
                end
                for (int k = 0; k < got_addr.size() && k < exp_addr.size(); k++) begin
                    checks++;
                    if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
                        failures++;
                        $display("[TB] FAIL rand_word[%0d.%0d.%0d]: got %0d/%h expected %0d/%h",
                                 it, n, k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
                    end
                end
                checks++;
                if (chk_at_done !== exp_sum) begin
                    failures++;
                    $display("[TB] FAIL rand_checksum[%0d.%0d]: got %h expected %h", it, n, chk_at_done, exp_sum);
                end
            end
        end
    endtask

    task automatic test_reset_mid_dump;
        bit hit;
        hit = 0;
        sel = 2'd0;
        for (int i = 0; i < 32; i++) grf[0][i] = 32'(i * 16);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (obs_valid && obs_addr == 5'd10) begin
                ready = 1'b0;
                reset = 1'b1;
                start = 1'b1;
                hit = 1;
                break;
            end
            ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("[TB] FAIL midreset_reach: got no word 10 within 100 cycles expected word 10 in HOLD");
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        checks++;
        if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_chk !== 32'h0 || obs_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_state: got valid=%b busy=%b chk=%h done=%b expected 0 0 0 0", obs_valid, obs_busy, obs_chk, obs_done);
        end
        @(negedge clk);
        checks++;
        if (obs_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_start_override: got busy=%b expected 0", obs_busy);
        end
        build_model(0);
        run_dump(0, 0);
        checks++;
        if (timed_out || got_addr.size() != 32 || got_addr[0] !== 5'd0) begin
            failures++;
            $display("[TB] FAIL midreset_restart: got %0d words expected 32 starting at 0", got_addr.size());
        end
        checks++;
        if (chk_at_done !== exp_sum || done_cyc != exp_cycles) begin
            failures++;
            $display("[TB] FAIL midreset_checksum: got %h cycle %0d expected %h cycle %0d", chk_at_done, done_cyc, exp_sum, exp_cycles);
        end
    endtask

    initial begin
        for (int n = 0; n < 3; n++)
            for (int i = 0; i < 32; i++) grf[n][i] = 32'h0;
        test_reset;
        test_full_dump;
        test_backpressure;
        test_skip_zero;
        test_wrap_ignored_start;
        test_random;
        test_reset_mid_dump;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
